// File: rtl/tff_pkg.sv
// rtl/tff_pkg.sv - mode encodings for the T flip-flop bank counter
package tff_pkg;

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_HOLD   = 2'b11
    } tff_mode_e;

endpackage

// File: rtl/t_ff_cell.sv
// rtl/t_ff_cell.sv - single T flip-flop cell with asynchronous reset to RstVal
module t_ff_cell (
    input  logic Clock,
    input  logic Reset_n,
    input  logic RstVal,
    input  logic T,
    output logic Q,
    output logic Qb
);

    logic q_q;
    logic q_d;

    assign q_d = q_q ^ T;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            q_q <= RstVal;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q  = q_q;
    assign Qb = ~q_q;

endmodule

// File: rtl/tff_bank_counter.sv
// rtl/tff_bank_counter.sv - WIDTH-bit T flip-flop bank with toggle/up/down/hold modes
module tff_bank_counter
    import tff_pkg::*;
#(
    parameter int                      WIDTH     = 8,
    parameter longint unsigned         MODULUS   = 64'd1 << WIDTH,
    parameter logic [WIDTH-1:0]        RESET_VAL = '0
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             En,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] T,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qb,
    output logic             Wrap
);

    // Modulus compares run one bit wider so MODULUS = 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_W  = MODULUS[WIDTH:0];
    localparam logic [WIDTH:0]   LAST_W = MOD_W - {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] LAST_Q = LAST_W[WIDTH-1:0];

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] teff;
    logic [WIDTH:0]   q_ext;
    logic             wrap_d;
    logic             wrap_q;
    tff_mode_e        mode;

    assign q_ext = {1'b0, Q};
    assign mode  = tff_mode_e'(Mode);

    always_comb begin
        q_next = Q;
        wrap_d = 1'b0;
        if (En) begin
            if (Load) begin
                q_next = ({1'b0, D} < MOD_W) ? D : LAST_Q;
            end else begin
                case (mode)
                    MODE_TOGGLE: q_next = Q ^ T;
                    MODE_UP: begin
                        if (q_ext >= LAST_W) begin
                            q_next = '0;
                            wrap_d = 1'b1;
                        end else begin
                            q_next = Q + {{(WIDTH-1){1'b0}}, 1'b1};
                        end
                    end
                    MODE_DOWN: begin
                        if (Q == '0 || q_ext >= MOD_W) begin
                            q_next = LAST_Q;
                            wrap_d = 1'b1;
                        end else begin
                            q_next = Q - {{(WIDTH-1){1'b0}}, 1'b1};
                        end
                    end
                    default: q_next = Q;
                endcase
            end
        end
    end

    // Cells only ever see a toggle vector, loads included.
    assign teff = Q ^ q_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_ff_cell u_cell (
            .Clock  (Clock),
            .Reset_n(Reset_n),
            .RstVal (RESET_VAL[i]),
            .T      (teff[i]),
            .Q      (Q[i]),
            .Qb     (Qb[i])
        );
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign Wrap = wrap_q;

endmodule

// File: tb/tb_tff_bank_counter.sv
// tb/tb_tff_bank_counter.sv - self-checking bench for tff_bank_counter
module tb_tff_bank_counter;

    logic       clk;
    logic       rst_n;

    logic       a_en, a_load;
    logic [7:0] a_d, a_t, a_q, a_qb;
    logic [1:0] a_mode;
    logic       a_wrap;

    logic       b_en, b_load;
    logic [3:0] b_d, b_t, b_q, b_qb;
    logic [1:0] b_mode;
    logic       b_wrap;

    int checks = 0;
    int errors = 0;

    int ma_q = 5;
    bit ma_w = 0;
    int mb_q = 0;
    bit mb_w = 0;

    tff_bank_counter #(.WIDTH(8), .MODULUS(10), .RESET_VAL(8'd5)) dut_a (
        .Clock(clk), .Reset_n(rst_n), .En(a_en), .Load(a_load), .D(a_d),
        .Mode(a_mode), .T(a_t), .Q(a_q), .Qb(a_qb), .Wrap(a_wrap)
    );

    tff_bank_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(4'd0)) dut_b (
        .Clock(clk), .Reset_n(rst_n), .En(b_en), .Load(b_load), .D(b_d),
        .Mode(b_mode), .T(b_t), .Q(b_q), .Qb(b_qb), .Wrap(b_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model(inout int q, output bit w, input bit en, input bit load,
                         input int d, input int mode, input int t,
                         input int m, input int width);
        int mask;
        mask = (1 << width) - 1;
        w = 0;
        if (!en) begin
        end else if (load) begin
            q = (d < m) ? d : m - 1;
        end else if (mode == 0) begin
            q = (q ^ t) & mask;
        end else if (mode == 1) begin
            if (q >= m - 1) begin q = 0; w = 1; end
            else q = q + 1;
        end else if (mode == 2) begin
            if (q == 0 || q >= m) begin q = m - 1; w = 1; end
            else q = q - 1;
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] ea;
        logic [3:0] eb;
        ea = 8'(ma_q);
        eb = 4'(mb_q);
        checks += 6;
        assert (a_q === ea) else begin errors++; $error("FAIL %s A.Q observed %0h expected %0h", tag, a_q, ea); end
        assert (a_qb === ~ea) else begin errors++; $error("FAIL %s A.Qb observed %0h expected %0h", tag, a_qb, ~ea); end
        assert (a_wrap === ma_w) else begin errors++; $error("FAIL %s A.Wrap observed %0b expected %0b", tag, a_wrap, ma_w); end
        assert (b_q === eb) else begin errors++; $error("FAIL %s B.Q observed %0h expected %0h", tag, b_q, eb); end
        assert (b_qb === ~eb) else begin errors++; $error("FAIL %s B.Qb observed %0h expected %0h", tag, b_qb, ~eb); end
        assert (b_wrap === mb_w) else begin errors++; $error("FAIL %s B.Wrap observed %0b expected %0b", tag, b_wrap, mb_w); end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model(ma_q, ma_w, a_en, a_load, int'(a_d), int'(a_mode), int'(a_t), 10, 8);
        model(mb_q, mb_w, b_en, b_load, int'(b_d), int'(b_mode), int'(b_t), 16, 4);
        #1;
        check_all(tag);
    endtask

    task automatic check_const(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin errors++; $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v); end
    endtask

    task automatic drive_a(input bit en, input bit load, input logic [7:0] d,
                           input logic [1:0] mode, input logic [7:0] t);
        a_en = en; a_load = load; a_d = d; a_mode = mode; a_t = t;
    endtask

    task automatic drive_b(input bit en, input bit load, input logic [3:0] d,
                           input logic [1:0] mode, input logic [3:0] t);
        b_en = en; b_load = load; b_d = d; b_mode = mode; b_t = t;
    endtask

    initial begin
        rst_n = 1'b1;
        drive_a(0, 0, 8'h00, 2'b11, 8'h00);
        drive_b(0, 0, 4'h0, 2'b11, 4'h0);
        #1 rst_n = 1'b0;
        #2;
        ma_q = 5; ma_w = 0; mb_q = 0; mb_w = 0;
        check_all("reset");
        check_const("reset_qb_const", a_qb, 8'hFA);
        @(negedge clk);
        rst_n = 1'b1;

        // Up count modulo 10 from 0
        drive_a(1, 1, 8'h00, 2'b01, 8'h00);
        tick("load0");
        drive_a(1, 0, 8'h00, 2'b01, 8'h00);
        for (int i = 0; i < 12; i++) begin
            tick("up10");
            if (i == 9) begin
                check_const("up_wrap_q", a_q, 8'h00);
                check_const("up_wrap_pulse", {7'b0, a_wrap}, 8'h01);
            end
        end

        // Load clamp then down count
        drive_a(1, 1, 8'hFF, 2'b10, 8'h00);
        tick("load_clamp");
        check_const("clamp_q", a_q, 8'h09);
        drive_a(1, 0, 8'h00, 2'b10, 8'h00);
        for (int i = 0; i < 10; i++) tick("down10");
        check_const("down_wrap_q", a_q, 8'h09);

        // Toggle mode and priorities
        drive_a(1, 1, 8'h00, 2'b00, 8'h00);
        tick("load0b");
        drive_a(1, 0, 8'h00, 2'b00, 8'h0F);
        tick("toggle_0f");
        drive_a(1, 0, 8'h00, 2'b00, 8'hFF);
        tick("toggle_ff");
        check_const("toggle_f0", a_q, 8'hF0);
        drive_a(1, 0, 8'h00, 2'b10, 8'h00);
        tick("down_over_mod");
        drive_a(1, 0, 8'h00, 2'b00, 8'hF9);
        tick("toggle_back");
        drive_a(1, 0, 8'h00, 2'b01, 8'h00);
        tick("up_over_mod");
        drive_a(1, 1, 8'h03, 2'b00, 8'hFF);
        tick("load_beats_toggle");
        check_const("load_prio", a_q, 8'h03);
        drive_a(0, 1, 8'h07, 2'b01, 8'hFF);
        tick("en_low");
        tick("en_low2");
        drive_a(1, 0, 8'h00, 2'b11, 8'hFF);
        tick("hold");

        // Mid-cycle reset during up count
        drive_a(1, 1, 8'h06, 2'b01, 8'h00);
        tick("load6");
        drive_a(1, 0, 8'h00, 2'b01, 8'h00);
        tick("up_to7");
        #2 rst_n = 1'b0;
        #1;
        ma_q = 5; ma_w = 0; mb_q = 0; mb_w = 0;
        check_all("mid_reset");
        #2 rst_n = 1'b1;
        tick("resume");
        check_const("resume_q", a_q, 8'h06);

        // Full-range wrap on 4-bit instance
        drive_a(0, 0, 8'h00, 2'b11, 8'h00);
        drive_b(1, 1, 4'hF, 2'b01, 4'h0);
        tick("b_load15");
        drive_b(1, 0, 4'h0, 2'b01, 4'h0);
        tick("b_up_wrap");
        check_const("b_up_wrap_flag", {7'b0, b_wrap}, 8'h01);
        drive_b(1, 0, 4'h0, 2'b10, 4'h0);
        tick("b_down_wrap");
        check_const("b_down_q", {4'b0, b_q}, 8'h0F);

        // Randomized traffic on both instances
        for (int i = 0; i < 300; i++) begin
            drive_a(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0),
                    8'($urandom), 2'($urandom), 8'($urandom));
            drive_b(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0),
                    4'($urandom), 2'($urandom), 4'($urandom));
            tick("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
